// File: rtl/cordic_pkg.sv
// Shared constants, arctangent table and FSM state type for the CORDIC sin/cos engine.
package cordic_pkg;

    localparam int FIX_W     = 27;
    localparam int FRAC_W    = 23;
    localparam int CNT_W     = 5;
    localparam int ATAN_FRAC = 26;
    localparam int ATAN_N    = 26;

    localparam logic signed [FIX_W-1:0] PI_Q      = 27'sh1921FB5;
    localparam logic signed [FIX_W-1:0] HALF_PI_Q = 27'sh0C90FDB;
    localparam logic signed [FIX_W-1:0] K_Q       = 27'sh04DBA77;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        FINAL = 2'd2
    } state_t;

    // round(atan(2^-idx) * 2^26), i.e. the table for the default three guard bits.
    function automatic logic signed [31:0] atan_raw(input int idx);
        logic signed [31:0] val;
        case (idx)
            0:       val = 32'sd52707179;
            1:       val = 32'sd31114864;
            2:       val = 32'sd16440240;
            3:       val = 32'sd8345322;
            4:       val = 32'sd4188855;
            5:       val = 32'sd2096470;
            6:       val = 32'sd1048491;
            7:       val = 32'sd524277;
            8:       val = 32'sd262143;
            9:       val = 32'sd131072;
            10:      val = 32'sd65536;
            11:      val = 32'sd32768;
            12:      val = 32'sd16384;
            13:      val = 32'sd8192;
            14:      val = 32'sd4096;
            15:      val = 32'sd2048;
            16:      val = 32'sd1024;
            17:      val = 32'sd512;
            18:      val = 32'sd256;
            19:      val = 32'sd128;
            20:      val = 32'sd64;
            21:      val = 32'sd32;
            22:      val = 32'sd16;
            23:      val = 32'sd8;
            24:      val = 32'sd4;
            25:      val = 32'sd2;
            default: val = 32'sd0;
        endcase
        return val;
    endfunction

    // Rescales the table entry to 23+guard fractional bits (rounding when guard < 3).
    function automatic logic signed [31:0] atan_q(input int idx, input int guard);
        logic signed [31:0] raw;
        raw = atan_raw(idx);
        if (guard >= ATAN_FRAC - FRAC_W) begin
            return raw <<< (guard - (ATAN_FRAC - FRAC_W));
        end
        return (raw + (32'sd1 <<< (ATAN_FRAC - FRAC_W - guard - 1)))
               >>> (ATAN_FRAC - FRAC_W - guard);
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One combinational CORDIC micro-rotation in rotation mode.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int W = 30
)(
    input  logic signed [W-1:0]     i_x,
    input  logic signed [W-1:0]     i_y,
    input  logic signed [W-1:0]     i_z,
    input  logic        [CNT_W-1:0] i_shift,
    input  logic signed [W-1:0]     i_atan,
    output logic signed [W-1:0]     o_x,
    output logic signed [W-1:0]     o_y,
    output logic signed [W-1:0]     o_z
);

    logic signed [W-1:0] w_xShift;
    logic signed [W-1:0] w_yShift;

    // Rotate towards z = 0: direction follows the sign of the residual angle.
    always_comb begin
        w_xShift = i_x >>> i_shift;
        w_yShift = i_y >>> i_shift;
        if (!i_z[W-1]) begin
            o_x = i_x - w_yShift;
            o_y = i_y + w_xShift;
            o_z = i_z - i_atan;
        end else begin
            o_x = i_x + w_yShift;
            o_y = i_y - w_xShift;
            o_z = i_z + i_atan;
        end
    end

endmodule

// File: rtl/cordic_sincos_iter.sv
// Iterative rotation-mode CORDIC: 4.23 angle in, 4.23 sin/cos out, one micro-rotation per clock.
module cordic_sincos_iter
    import cordic_pkg::*;
#(
    parameter int ITERS = 24,
    parameter int GUARD = 3
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [FIX_W-1:0] angle_in,
    input  logic                    in_invalid,
    output logic                    busy,
    output logic                    done,
    output logic signed [FIX_W-1:0] sin_out,
    output logic signed [FIX_W-1:0] cos_out,
    output logic                    err
);

    localparam int W = FIX_W + GUARD;
    localparam logic [CNT_W-1:0]    LAST_ITER  = CNT_W'(ITERS - 1);
    localparam logic signed [W-1:0] ROUND_HALF = W'(1 << (GUARD - 1));

    state_t r_state;
    state_t w_nextState;

    logic signed [W-1:0]     r_x;
    logic signed [W-1:0]     r_y;
    logic signed [W-1:0]     r_z;
    logic [CNT_W-1:0]        r_iter;
    logic                    r_neg;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_err;
    logic signed [FIX_W-1:0] r_sin;
    logic signed [FIX_W-1:0] r_cos;

    logic                    w_reject;
    logic                    w_foldNeg;
    logic signed [FIX_W-1:0] w_foldAngle;
    logic                    w_accept;
    logic                    w_rejectReq;
    logic                    w_finish;
    logic signed [W-1:0]     w_atan;
    logic signed [W-1:0]     w_xNext;
    logic signed [W-1:0]     w_yNext;
    logic signed [W-1:0]     w_zNext;
    logic signed [FIX_W-1:0] w_xRes;
    logic signed [FIX_W-1:0] w_yRes;

    // Screen the request and fold angles beyond +-pi/2 back into CORDIC's convergence range.
    always_comb begin
        w_reject    = in_invalid || (angle_in > PI_Q) || (angle_in < -PI_Q);
        w_foldAngle = angle_in;
        w_foldNeg   = 1'b0;
        if (angle_in > HALF_PI_Q) begin
            w_foldAngle = angle_in - PI_Q;
            w_foldNeg   = 1'b1;
        end else if (angle_in < -HALF_PI_Q) begin
            w_foldAngle = angle_in + PI_Q;
            w_foldNeg   = 1'b1;
        end
    end

    // Next-state logic and the one-cycle control strobes that drive the datapath.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_rejectReq = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_reject) begin
                        w_rejectReq = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_nextState = ITER;
                    end
                end
            end
            ITER: begin
                if (r_iter == LAST_ITER) begin
                    w_nextState = FINAL;
                end
            end
            FINAL: begin
                w_finish    = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    assign w_atan = W'(atan_q(int'(r_iter), GUARD));

    cordic_stage #(
        .W (W)
    ) u_stage (
        .i_x     (r_x),
        .i_y     (r_y),
        .i_z     (r_z),
        .i_shift (r_iter),
        .i_atan  (w_atan),
        .o_x     (w_xNext),
        .o_y     (w_yNext),
        .o_z     (w_zNext)
    );

    // Drop the guard bits with round-half-up, then undo the fold by negating both results.
    always_comb begin
        w_xRes = FIX_W'((r_x + ROUND_HALF) >>> GUARD);
        w_yRes = FIX_W'((r_y + ROUND_HALF) >>> GUARD);
        if (r_neg) begin
            w_xRes = -w_xRes;
            w_yRes = -w_yRes;
        end
    end

    // Datapath and output registers: load on accept, rotate while iterating, publish at the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
            r_iter <= '0;
            r_neg  <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_sin  <= '0;
            r_cos  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_rejectReq) begin
                r_done <= 1'b1;
                r_err  <= 1'b1;
                r_sin  <= '0;
                r_cos  <= '0;
            end
            if (w_accept) begin
                r_busy <= 1'b1;
                r_err  <= 1'b0;
                r_x    <= {K_Q, {GUARD{1'b0}}};
                r_y    <= '0;
                r_z    <= {w_foldAngle, {GUARD{1'b0}}};
                r_neg  <= w_foldNeg;
                r_iter <= '0;
            end
            if (r_state == ITER) begin
                r_x <= w_xNext;
                r_y <= w_yNext;
                r_z <= w_zNext;
                if (r_iter != LAST_ITER) begin
                    r_iter <= r_iter + 1'b1;
                end
            end
            if (w_finish) begin
                r_cos  <= w_xRes;
                r_sin  <= w_yRes;
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign sin_out = r_sin;
    assign cos_out = r_cos;
    assign err     = r_err;

endmodule

// File: tb/tb_cordic_sincos_iter.sv
// Directed self-checking bench for cordic_sincos_iter with hand-computed sin/cos targets.
module tb_cordic_sincos_iter;

    localparam int LAT     = 26;
    localparam int TOL     = 8;
    localparam int ONE_Q   = 8388608;
    localparam int HALF_PI = 13176795;
    localparam int PI_INT  = 26353589;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic signed [26:0] angle_in;
    logic               in_invalid;
    logic               busy;
    logic               done;
    logic signed [26:0] sin_out;
    logic signed [26:0] cos_out;
    logic               err;

    int checkCount;
    int errorCount;

    cordic_sincos_iter #(
        .ITERS (24),
        .GUARD (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .angle_in   (angle_in),
        .in_invalid (in_invalid),
        .busy       (busy),
        .done       (done),
        .sin_out    (sin_out),
        .cos_out    (cos_out),
        .err        (err)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected, input int tol);
        int diff;
        checkCount++;
        diff = observed - expected;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d (tol %0d)", tag, observed, expected, tol);
        end
    endtask

    // Raise start at the current negedge; it is sampled by the next posedge (cycle 0).
    task automatic applyStimulus(input logic signed [26:0] a, input logic inv);
        start      = 1'b1;
        angle_in   = a;
        in_invalid = inv;
    endtask

    // Walk cycle by cycle until done, optionally firing a stray start while busy.
    task automatic waitDone(input int intrudeAt, output int lat, output logic busy1, output logic busyAtDone);
        lat        = -1;
        busy1      = 1'b0;
        busyAtDone = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) busy1 = busy;
            if (done) begin
                lat        = k;
                busyAtDone = busy;
                break;
            end
            if (k == 1) begin
                start      = 1'b0;
                in_invalid = 1'b0;
                angle_in   = 27'sd22369621;
            end
            if (intrudeAt > 0 && k == intrudeAt) begin
                start    = 1'b1;
                angle_in = 27'(HALF_PI);
            end else if (intrudeAt > 0 && k == intrudeAt + 1) begin
                start = 1'b0;
            end
        end
        start      = 1'b0;
        in_invalid = 1'b0;
    endtask

    task automatic runOp(input string name, input logic signed [26:0] a, input logic inv,
                         input int expLat, input int expErr, input int expSin, input int expCos,
                         input int intrudeAt, input bit holdCheck);
        int   lat;
        int   tol;
        logic busy1;
        logic busyAtDone;
        tol = (expErr != 0) ? 0 : TOL;
        applyStimulus(a, inv);
        waitDone(intrudeAt, lat, busy1, busyAtDone);
        checkOutput({name, " latency"}, lat, expLat, 0);
        checkOutput({name, " busy_c1"}, int'(busy1), (expLat > 1) ? 1 : 0, 0);
        checkOutput({name, " busy_done"}, int'(busyAtDone), 0, 0);
        checkOutput({name, " err"}, int'(err), expErr, 0);
        checkOutput({name, " sin"}, int'(sin_out), expSin, tol);
        checkOutput({name, " cos"}, int'(cos_out), expCos, tol);
        if (holdCheck) begin
            @(negedge clk);
            checkOutput({name, " done_pulse"}, int'(done), 0, 0);
            checkOutput({name, " busy_after"}, int'(busy), 0, 0);
            checkOutput({name, " sin_held"}, int'(sin_out), expSin, tol);
            checkOutput({name, " err_held"}, int'(err), expErr, 0);
        end
    endtask

    initial begin
        int doneSeen;
        checkCount = 0;
        errorCount = 0;
        clk        = 1'b0;
        rst_n      = 1'b0;
        start      = 1'b0;
        angle_in   = '0;
        in_invalid = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset busy", int'(busy), 0, 0);
        checkOutput("reset done", int'(done), 0, 0);
        checkOutput("reset sin", int'(sin_out), 0, 0);
        checkOutput("reset cos", int'(cos_out), 0, 0);
        checkOutput("reset err", int'(err), 0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        runOp("zero", 27'sd0, 1'b0, LAT, 0, 0, ONE_Q, 0, 1'b1);
        runOp("pi/2", 27'(HALF_PI), 1'b0, LAT, 0, ONE_Q, 0, 0, 1'b1);
        runOp("-pi/2", -27'(HALF_PI), 1'b0, LAT, 0, -ONE_Q, 0, 0, 1'b1);
        runOp("-pi/6", -27'sd4392265, 1'b0, LAT, 0, -4194304, 7264748, 0, 1'b1);
        runOp("3pi/4", 27'sd19765192, 1'b0, LAT, 0, 5931642, -5931642, 0, 1'b1);
        runOp("pi", 27'(PI_INT), 1'b0, LAT, 0, 0, -ONE_Q, 0, 1'b1);

        runOp("angle4", 27'sh2000000, 1'b0, 1, 1, 0, 0, 0, 1'b1);
        runOp("invalid", 27'sd0, 1'b1, 1, 1, 0, 0, 0, 1'b1);
        runOp("pi+1", 27'(PI_INT + 1), 1'b0, 1, 1, 0, 0, 0, 1'b1);

        runOp("intrude", 27'sd0, 1'b0, LAT, 0, 0, ONE_Q, 5, 1'b1);
        doneSeen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkOutput("intrude extra_done", doneSeen, 0, 0);

        runOp("b2b first", 27'sd19765192, 1'b0, LAT, 0, 5931642, -5931642, 0, 1'b0);
        runOp("b2b second", -27'sd4392265, 1'b0, LAT, 0, -4194304, 7264748, 0, 1'b1);

        applyStimulus(27'(HALF_PI), 1'b0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("abort busy", int'(busy), 0, 0);
        checkOutput("abort sin", int'(sin_out), 0, 0);
        checkOutput("abort cos", int'(cos_out), 0, 0);
        checkOutput("abort err", int'(err), 0, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        doneSeen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkOutput("abort no_done", doneSeen, 0, 0);

        runOp("-pi", -27'(PI_INT), 1'b0, LAT, 0, 0, -ONE_Q, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/cordic_sincos_iter.md
Name: cordic_sincos_iter

Overview:
- Iterative rotation-mode CORDIC engine. Sits directly downstream of the float-to-fixed converter.
- Consumes a 27-bit signed 4.23 fixed-point angle in radians, plus that converter's invalid flag.
- Produces sin and cos in the same 4.23 format, one micro-rotation per clock.
- Results feed the fixed-to-float stage and the peripheral register file.

Parameters:
- ITERS, 24, number of micro-rotations (range 8..26).
- GUARD, 3, extra LSBs carried internally on x/y/z to bound rounding error.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only while busy=0.
- angle_in  in  27  signed 4.23 angle in radians; sampled with start.
- in_invalid  in  1  NaN/Inf flag from the upstream converter; sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when results are valid.
- sin_out  out  27  signed 4.23 sine; held until the next accepted start.
- cos_out  out  27  signed 4.23 cosine; held until the next accepted start.
- err  out  1  result invalid (invalid input or |angle| > π); held like the results.

Behaviour:
- Reset is asynchronous: busy=0, done=0, sin_out=0, cos_out=0, err=0, state=IDLE, iteration counter=0.
- Internal width is W = 27 + GUARD. x, y, z are signed W-bit values, scaled 4.(23+GUARD).
- FSM states: IDLE, ITER, FINAL.
- IDLE:
  - start=1 with in_invalid=1 → next cycle done=1, err=1, sin_out=cos_out=0, stay IDLE. busy never rises.
  - start=1 with |angle_in| > PI_Q (0x1921FB5) → same response as the invalid case.
  - Otherwise the request is accepted: load and go to ITER with busy=1, err cleared.
- Load and quadrant fold:
  - angle > PI_Q/2 (0x0C90FDB): z0 = angle − PI_Q, neg=1.
  - angle < −PI_Q/2: z0 = angle + PI_Q, neg=1.
  - Otherwise z0 = angle, neg=0.
  - x0 = K_Q << GUARD, where K_Q = round(0.6072529350·2^23) = 5094007 (0x4DBA77). y0 = 0. i = 0.
- ITER, one micro-rotation per cycle:
  - d = (z ≥ 0) ? +1 : −1.
  - x' = x − d·(y >>> i); y' = y + d·(x >>> i); z' = z − d·ATAN[i].
  - Shifts are arithmetic.
  - After the step with i = ITERS−1, go to FINAL; otherwise i increments.
- FINAL:
  - Round x and y to 27 bits: add 1<<(GUARD−1), then arithmetic shift right by GUARD.
  - If neg=1, negate both. Register the results into cos_out and sin_out.
  - Pulse done, drop busy, return to IDLE.
- Latency: start accepted in cycle 0 → done in cycle ITERS+2 (26 at the default). busy is high in cycles 1..ITERS+1.
- Back-to-back operation: start may be asserted in the same cycle as done; it is accepted, and the new op begins the following cycle.
- start while busy=1 is ignored and not queued. angle_in changes while busy have no effect.
- Overflow cannot occur: |x|,|y| ≤ 1.65 fits 4 integer bits. No saturation logic is required.
- Reset mid-operation aborts immediately: outputs go to their reset values and no done is produced.
- Accuracy: |error| ≤ 8 LSB of 4.23 for ITERS=24, GUARD=3, across all accepted inputs.

Decomposition:
- Package cordic_pkg holds:
  - FIX_W = 27 and FRAC_W = 23.
  - PI_Q, HALF_PI_Q, K_Q.
  - ATAN table: round(atan(2^−i)·2^(23+GUARD)) for i = 0..25, as a localparam array or function.
  - FSM state typedef {IDLE, ITER, FINAL}.
- One sub-module, cordic_stage: a purely combinational single micro-rotation taking x, y, z, i and ATAN[i] and returning x', y', z'. The top holds the FSM, registers and fold/unfold logic.

Test Plan:
- angle=0 → done at cycle 26. cos_out = 8388608 ±8, sin_out = 0 ±8, err=0.
- angle=0x0C90FDB (π/2) → sin_out = 8388608 ±8, cos_out = 0 ±8. Repeat with −π/2: sin_out = −8388608 ±8.
- angle=−4392265 (−π/6) → sin_out = −4194304 ±8, cos_out = 7264748 ±8.
- angle=19765192 (3π/4), fold path → cos_out = −5931642 ±8, sin_out = 5931642 ±8. Also angle=PI_Q → cos_out = −8388608 ±8.
- Error paths:
  - angle=0x2000000 (4.0) → done one cycle after start, err=1, outputs 0, busy stays 0.
  - in_invalid=1 with angle=0 → same response.
- Control paths:
  - Second start at cycle 5 of a busy op → ignored, single done at cycle 26.
  - start coincident with done → second result 26 cycles later.
  - rst_n low at cycle 10 → outputs 0, no done pulse.
